instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the 9-bit processor: owns the program counter, drives the instruction-memory read address and presents the fetched 9-bit word on `bits` to the control unit.
- Consumes the control unit's `branchEnable` and `LUTIndex` to redirect fetch through a 32-entry absolute branch-target LUT.
- A start/done handshake with the testbench frames each program run. A run-length cycle counter is provided for performance reporting.

Parameters:
- PC_WIDTH, 10, width of PC, imem address and LUT entries.
- LUT_DEPTH, 32, number of branch-target LUT entries (indexed by the 5-bit LUTIndex).
- HALT_WORD, 9'h1FF, instruction encoding that terminates a run.
- CNT_WIDTH, 16, width of cycle_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from PC 0 (honoured in IDLE or DONE only).
- stall  in  1  holds PC and suppresses branch/halt evaluation this cycle.
- branchEnable  in  1  from control unit; redirect fetch this cycle.
- LUTIndex  in  5  from control unit; selects branch-target LUT entry.
- lut_wr_en  in  1  LUT write strobe (legal in any state).
- lut_wr_addr  in  5  LUT write index.
- lut_wr_data  in  PC_WIDTH  absolute branch target to store.
- imem_addr  out  PC_WIDTH  instruction memory address (= pc).
- imem_data  in  9  instruction memory read data (combinational read of imem_addr).
- bits  out  9  current instruction to control unit.
- pc  out  PC_WIDTH  current program counter.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.
- cycle_count  out  CNT_WIDTH  RUN cycles elapsed in current/last run.

Behaviour:
- Clocking and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: state=IDLE, pc=0, all LUT entries=0, cycle_count=0, running=0, done=0. `bits` = imem_data combinationally, but control consumers must qualify it with `running`.
- States: IDLE, RUN, DONE.
  - IDLE: pc holds. On start, pc<=0, cycle_count<=0, go to RUN.
  - RUN, with stall=1: pc and state hold; branchEnable is ignored; cycle_count still increments.
  - RUN, with stall=0 and bits==HALT_WORD: go to DONE; pc holds at the HALT address; cycle_count increments this final time. The halt check takes priority over branchEnable.
  - RUN, with stall=0 and branchEnable=1: pc<=LUT[LUTIndex] (absolute target); cycle_count++.
  - RUN, otherwise: pc<=pc+1, wrapping modulo 2^PC_WIDTH (1023 -> 0 at default); cycle_count++.
  - DONE: done=1, pc and cycle_count hold. On start, pc<=0, cycle_count<=0, go to RUN.
  - start asserted while in RUN: ignored.
- Latency:
  - A redirect takes effect on the next edge, so the target instruction appears on `bits` one cycle after branchEnable was sampled high.
  - There is no delay slot and no prefetch.
- cycle_count saturates at all-ones and never wraps.
- LUT:
  - Write is synchronous.
  - A write and a branch read of the same index in the same cycle: the branch uses the old entry; the new value is visible from the next cycle.
  - lut_wr_data width is PC_WIDTH; no truncation.
- Reset asserted mid-run: next cycle is IDLE with all reset values, including the LUT cleared. A start on the same cycle as reset is ignored.
- running = (state==RUN); done = (state==DONE); both are registered-state decodes with no glitching paths from inputs.

Test Plan:
- Reset, then start with imem words 0x000, 0x010, 0x020, 0x1FF at addresses 0..3 and no branches:
  - pc steps 0,1,2,3.
  - done rises on the cycle after pc=3.
  - cycle_count=4, pc holds at 3.
- LUT[5]=0x040 written while in IDLE; in RUN, branchEnable=1 with LUTIndex=5 at pc=2:
  - next pc=0x040.
  - bits=imem[0x040] one cycle later.
- Same cycle: lut_wr_en, addr 7, data 0x100, plus branchEnable with LUTIndex=7, where the old LUT[7]=0x080:
  - pc becomes 0x080.
  - A later branch via index 7 goes to 0x100.
- stall held 3 cycles at pc=9 with branchEnable=1 and a HALT word present:
  - pc stays 9 and the state stays RUN.
  - cycle_count still advances by 3.
- pc=1023 with a non-branch word:
  - pc wraps to 0.
- In DONE, start:
  - pc=0, cycle_count=0, running=1 next cycle.
- Reset asserted mid-run at pc=0x12:
  - next cycle pc=0, state IDLE, LUT[5] reads 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Front end of the 9-bit processor. Owns the program counter, drives the
//   instruction-memory read address and hands the fetched word to the control
//   unit. Branches redirect fetch through a 32-entry absolute-target LUT.
//   A start/done handshake frames each program run; a saturating counter
//   reports how many RUN cycles the run took.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   start        in   one-cycle pulse; starts a run from PC 0 (IDLE/DONE only)
//   stall        in   holds PC and suppresses branch/halt evaluation
//   branchEnable in   redirect fetch to LUT[LUTIndex] this cycle
//   LUTIndex     in   branch-target LUT index
//   lut_wr_en    in   LUT write strobe
//   lut_wr_addr  in   LUT write index
//   lut_wr_data  in   absolute branch target to store
//   imem_addr    out  instruction memory address (= pc)
//   imem_data    in   instruction memory read data (combinational)
//   bits         out  current instruction (qualify with running)
//   pc           out  current program counter
//   running      out  high while in RUN
//   done         out  high while in DONE
//   cycle_count  out  RUN cycles elapsed in the current/last run
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int          PC_WIDTH  = 10,
    parameter int          LUT_DEPTH = 32,
    parameter logic [8:0]  HALT_WORD = 9'h1FF,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 branchEnable,
    input  logic [4:0]           LUTIndex,
    input  logic                 lut_wr_en,
    input  logic [4:0]           lut_wr_addr,
    input  logic [PC_WIDTH-1:0]  lut_wr_data,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic [8:0]           imem_data,
    output logic [8:0]           bits,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 running,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]   lut_q [LUT_DEPTH];

    logic                  halt_seen;

    assign halt_seen = (imem_data == HALT_WORD);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A stalled cycle never evaluates the halt word.
                if (!stall && halt_seen) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: pure functions of the registered state
    always_comb begin
        running = (state_q == RUN);
        done    = (state_q == DONE);
    end

    // PC and cycle counter next values
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pc_d  = '0;
                    cnt_d = '0;
                end
            end
            RUN: begin
                // Counter advances on every RUN cycle, stalled or not,
                // and sticks at all-ones.
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                if (!stall) begin
                    // Halt has priority over a branch: PC stays on the halt word.
                    if (halt_seen) begin
                        pc_d = pc_q;
                    end else if (branchEnable) begin
                        pc_d = lut_q[LUTIndex];
                    end else begin
                        pc_d = pc_q + PC_WIDTH'(1);
                    end
                end
            end
            default: begin
                pc_d  = '0;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    // Branch-target LUT. A same-cycle write and branch read of one entry
    // returns the old value because the read is from the registered array.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_wr_en) begin
            lut_q[lut_wr_addr] <= lut_wr_data;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign bits        = imem_data;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int PCW = 10;
    localparam int CW  = 16;

    logic           clk;
    logic           reset;
    logic           start;
    logic           stall;
    logic           branchEnable;
    logic [4:0]     LUTIndex;
    logic           lut_wr_en;
    logic [4:0]     lut_wr_addr;
    logic [PCW-1:0] lut_wr_data;
    logic [PCW-1:0] imem_addr;
    logic [8:0]     imem_data;
    logic [8:0]     bits;
    logic [PCW-1:0] pc;
    logic           running;
    logic           done;
    logic [CW-1:0]  cycle_count;

    logic [8:0] imem [1024];

    assign imem_data = imem[imem_addr];

    instr_fetch_unit #(
        .PC_WIDTH (PCW),
        .LUT_DEPTH(32),
        .HALT_WORD(9'h1FF),
        .CNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .branchEnable(branchEnable),
        .LUTIndex    (LUTIndex),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_addr (lut_wr_addr),
        .lut_wr_data (lut_wr_data),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .bits        (bits),
        .pc          (pc),
        .running     (running),
        .done        (done),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int { K_PC, K_RUN, K_DONE, K_CNT, K_BITS } kind_t;

    typedef struct {
        string       tag;
        kind_t       kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue the expected post-edge state for the stimulus just driven.
    task automatic expect_all(input string tag, input int epc, input int erun,
                              input int edone, input int ecnt);
        exp_q.push_back('{tag: {tag, ".pc"},   kind: K_PC,   val: 32'(epc)});
        exp_q.push_back('{tag: {tag, ".run"},  kind: K_RUN,  val: 32'(erun)});
        exp_q.push_back('{tag: {tag, ".done"}, kind: K_DONE, val: 32'(edone)});
        exp_q.push_back('{tag: {tag, ".cnt"},  kind: K_CNT,  val: 32'(ecnt)});
    endtask

    task automatic expect_bits(input string tag, input int ebits);
        exp_q.push_back('{tag: tag, kind: K_BITS, val: 32'(ebits)});
    endtask

    // Advance one clock, then pop and compare everything queued.
    task automatic tick();
        exp_t e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_PC:    obs = 32'(pc);
                K_RUN:   obs = 32'(running);
                K_DONE:  obs = 32'(done);
                K_CNT:   obs = 32'(cycle_count);
                default: obs = 32'(bits);
            endcase
            check(e.tag, obs, e.val);
        end
        reset        = 1'b0;
        start        = 1'b0;
        stall        = 1'b0;
        branchEnable = 1'b0;
        LUTIndex     = '0;
        lut_wr_en    = 1'b0;
        lut_wr_addr  = '0;
        lut_wr_data  = '0;
    endtask

    task automatic lut_write(input int idx, input int val);
        lut_wr_en   = 1'b1;
        lut_wr_addr = 5'(idx);
        lut_wr_data = PCW'(val);
    endtask

    task automatic branch(input int idx);
        branchEnable = 1'b1;
        LUTIndex     = 5'(idx);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 9'h000;
        imem[1]     = 9'h010;
        imem[2]     = 9'h020;
        imem[3]     = 9'h1FF;
        imem[9]     = 9'h1FF;
        imem[10'h40] = 9'h0AB;

        reset = 1'b1; start = 1'b0; stall = 1'b0; branchEnable = 1'b0;
        LUTIndex = '0; lut_wr_en = 1'b0; lut_wr_addr = '0; lut_wr_data = '0;
        @(posedge clk);
        #1;

        // Reset state
        reset = 1'b1;
        expect_all("rst", 0, 0, 0, 0);
        tick();

        // Straight-line run to HALT at address 3
        start = 1'b1;
        expect_all("p0", 0, 1, 0, 0);
        tick();
        expect_all("p1", 1, 1, 0, 1);
        tick();
        expect_all("p2", 2, 1, 0, 2);
        tick();
        expect_all("p3", 3, 1, 0, 3);
        expect_bits("p3.bits", 9'h1FF);
        tick();
        expect_all("halt", 3, 0, 1, 4);
        tick();
        expect_all("halt_hold", 3, 0, 1, 4);
        tick();

        // Fresh reset, LUT loaded in IDLE
        reset = 1'b1;
        expect_all("rst2", 0, 0, 0, 0);
        tick();
        lut_write(5, 10'h040);
        expect_all("wr5", 0, 0, 0, 0);
        tick();
        lut_write(1, 9);
        tick();
        lut_write(2, 1023);
        tick();
        lut_write(3, 10'h012);
        tick();
        lut_write(7, 10'h080);
        tick();

        start = 1'b1;
        expect_all("b0", 0, 1, 0, 0);
        tick();
        // start while running is ignored
        start = 1'b1;
        expect_all("b1_start_ign", 1, 1, 0, 1);
        tick();
        expect_all("b2", 2, 1, 0, 2);
        tick();
        branch(5);
        expect_all("br5", 10'h040, 1, 0, 3);
        expect_bits("br5.bits", 9'h0AB);
        tick();
        expect_all("br5_next", 10'h041, 1, 0, 4);
        tick();

        // Same-cycle LUT write and branch read of entry 7: old target wins
        lut_write(7, 10'h100);
        branch(7);
        expect_all("wr_rd7", 10'h080, 1, 0, 5);
        tick();
        expect_all("after7", 10'h081, 1, 0, 6);
        tick();
        branch(7);
        expect_all("br7_new", 10'h100, 1, 0, 7);
        tick();

        // Stall at pc=9 with HALT word present and branch requested
        branch(1);
        expect_all("to9", 9, 1, 0, 8);
        expect_bits("to9.bits", 9'h1FF);
        tick();
        for (int s = 0; s < 3; s++) begin
            stall = 1'b1;
            branch(5);
            expect_all($sformatf("stall%0d", s), 9, 1, 0, 9 + s);
            tick();
        end
        // Halt takes priority over branchEnable
        branch(5);
        expect_all("halt9", 9, 0, 1, 12);
        tick();
        expect_all("halt9_hold", 9, 0, 1, 12);
        tick();

        // Restart from DONE
        start = 1'b1;
        expect_all("restart", 0, 1, 0, 0);
        tick();

        // PC wrap at 1023
        branch(2);
        expect_all("to1023", 1023, 1, 0, 1);
        tick();
        expect_all("wrap", 0, 1, 0, 2);
        tick();

        // Reset mid-run at pc=0x12, with a coincident start
        branch(3);
        expect_all("to12", 10'h012, 1, 0, 3);
        tick();
        reset = 1'b1;
        start = 1'b1;
        expect_all("rst_mid", 0, 0, 0, 0);
        tick();
        expect_all("idle_hold", 0, 0, 0, 0);
        tick();
        start = 1'b1;
        expect_all("c0", 0, 1, 0, 0);
        tick();
        expect_all("c1", 1, 1, 0, 1);
        tick();
        expect_all("c2", 2, 1, 0, 2);
        tick();
        // LUT[5] was cleared by reset
        branch(5);
        expect_all("lut_clr", 0, 1, 0, 3);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
